// File: rtl/spi_master_ctrl_pkg.sv
// spi_pkg: definitions shared by the SPI master controller and the SPI
// slave/RAM subsystem.
//   cmd_t      - 2-bit frame command encodings
//   state_t    - master controller state enumeration
//   FRAME_BITS - length of the {cmd, payload} shift word
//   RD_BITS    - length of the read-data response
//   build_word - forms the transmitted word (read-data frames send a zero payload)
package spi_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    HDR,
    SHIFT,
    RECV,
    GAP
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int RD_BITS    = 8;

  function automatic logic [FRAME_BITS-1:0] build_word(input cmd_t cmd,
                                                      input logic [RD_BITS-1:0] payload);
    return {cmd, (cmd == CMD_RD_DATA) ? {RD_BITS{1'b0}} : payload};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: host-side request/response bundle of the SPI master.
//   start, cmd, wdata          - request from the host
//   busy, done, rd_valid, rdata - status and read response back to the host
// Modports:
//   master - the requesting host (drives the request)
//   slave  - the SPI master controller serving the request
interface spi_master_ctrl_if;
  import spi_pkg::*;

  logic               start;
  cmd_t               cmd;
  logic [RD_BITS-1:0] wdata;
  logic               busy;
  logic               done;
  logic [RD_BITS-1:0] rdata;
  logic               rd_valid;

  modport master (
    output start, cmd, wdata,
    input  busy, done, rdata, rd_valid
  );

  modport slave (
    input  start, cmd, wdata,
    output busy, done, rdata, rd_valid
  );

endinterface

// File: rtl/spi_master_ctrl_shift_reg.sv
// spi_shift_reg: data path of the SPI master.
//   load/load_word - parallel load of the {cmd, payload} TX word
//   shift_en       - shift the TX word left, MSB presented on tx_msb
//   rx_en/miso     - LSB-first capture of the MISO response
//   rx_next        - the response byte including the current MISO bit
module spi_shift_reg
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_word,
  input  logic                  shift_en,
  input  logic                  rx_en,
  input  logic                  miso,
  output logic                  tx_msb,
  output logic [RD_BITS-1:0]    rx_next
);

  logic [FRAME_BITS-1:0] tx_q;
  // Only seven samples are stored: the eighth is still on MISO at the edge
  // where the controller commits rdata, so it is merged in combinationally.
  logic [RD_BITS-2:0]    rx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load)
        tx_q <= load_word;
      else if (shift_en)
        tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
      if (rx_en)
        rx_q <= {miso, rx_q[RD_BITS-2:1]};
    end
  end

  assign tx_msb  = tx_q[FRAME_BITS-1];
  assign rx_next = {miso, rx_q};

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-cycle-per-bit SPI master. Sends a 2-bit command and
// an 8-bit payload MSB first on MOSI under SS_n; for read-data frames it then
// captures an 8-bit LSB-first response from MISO.
//   clk, rst_n     - system clock, synchronous active-low reset
//   host           - request/response bundle (spi_master_ctrl_if.slave)
//   SS_n/MOSI/MISO - SPI pins
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_ctrl_if.slave    host,
  output logic                SS_n,
  output logic                MOSI,
  input  logic                MISO
);

  state_t     state;
  logic [3:0] cnt;
  cmd_t       cmd_q;

  logic                  load;
  logic                  shift_en;
  logic                  rx_en;
  logic                  tx_msb;
  logic [RD_BITS-1:0]    rx_next;

  assign load     = (state == IDLE) && host.start;
  assign shift_en = (state == HDR) || (state == SHIFT);
  // The first RECV cycle is a turnaround cycle; MISO is sampled after it.
  assign rx_en    = (state == RECV) && (cnt != 4'd0);

  spi_shift_reg u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_word (build_word(host.cmd, host.wdata)),
    .shift_en  (shift_en),
    .rx_en     (rx_en),
    .miso      (MISO),
    .tx_msb    (tx_msb),
    .rx_next   (rx_next)
  );

  // MOSI is registered one stage behind the shifter, so tx_msb is always the
  // bit for the following cycle. HDR repeats cmd[1] before the full word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      cmd_q         <= CMD_WR_ADDR;
      SS_n          <= 1'b1;
      MOSI          <= 1'b0;
      host.busy     <= 1'b0;
      host.done     <= 1'b0;
      host.rd_valid <= 1'b0;
      host.rdata    <= '0;
    end else begin
      host.done     <= 1'b0;
      host.rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            state     <= SEL;
            cmd_q     <= host.cmd;
            SS_n      <= 1'b0;
            host.busy <= 1'b1;
          end
        end
        SEL: begin
          state <= HDR;
          MOSI  <= tx_msb;
        end
        HDR: begin
          state <= SHIFT;
          cnt   <= 4'd0;
          MOSI  <= tx_msb;
        end
        SHIFT: begin
          if (cnt == 4'(FRAME_BITS - 1)) begin
            cnt  <= 4'd0;
            MOSI <= 1'b0;
            if (cmd_q == CMD_RD_DATA) begin
              state <= RECV;
            end else begin
              state     <= GAP;
              SS_n      <= 1'b1;
              host.done <= 1'b1;
            end
          end else begin
            cnt  <= cnt + 4'd1;
            MOSI <= tx_msb;
          end
        end
        RECV: begin
          if (cnt == 4'(RD_BITS)) begin
            state         <= GAP;
            cnt           <= 4'd0;
            SS_n          <= 1'b1;
            host.done     <= 1'b1;
            host.rd_valid <= 1'b1;
            host.rdata    <= rx_next;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (cnt == 4'(GAP_CYCLES - 1)) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            host.busy <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Single-cycle-per-bit SPI master that initiates frames toward the SPI slave/RAM subsystem. It serialises a 2-bit command plus 8-bit payload on MOSI under SS_n, and for read-data commands it captures the 8-bit response returned on MISO. It sits between a host-side request interface and the SPI pins, sharing the system clock with the slave; there is no separate SCLK.

## Interface
- GAP_CYCLES, 2: minimum SS_n-high cycles between frames (≥1).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- cmd  in  2  00 write address, 01 write data, 10 read address, 11 read data.
- wdata  in  8  payload (address or data; ignored for cmd=11, sent as 0x00).
- busy  out  1  high from the cycle after start is accepted through the end of the gap.
- done  out  1  one-cycle pulse when a frame completes.
- rdata  out  8  captured read byte; holds until the next cmd=11 frame completes.
- rd_valid  out  1  one-cycle pulse with done when cmd=11.
- SS_n  out  1  active-low slave select.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

## Operation
- On start with busy=0, latch cmd/wdata into a 10-bit shift word {cmd, payload}, MSB first; ignore start while busy=1.
- States: IDLE, SEL, HDR, SHIFT, RECV, GAP.
  - IDLE: SS_n=1, MOSI=0. start → SEL.
  - SEL (1 cycle, T0): SS_n=0, MOSI=0.
  - HDR (1 cycle, T1): MOSI=cmd[1] (slave's command-check bit).
  - SHIFT (10 cycles, T2..T11): MOSI = word bit 9 down to 0. Then cmd=11 → RECV, else → GAP.
  - RECV (9 cycles, T12..T20): SS_n=0, MOSI=0; sample MISO on rising edges ending T13..T20, LSB first (first sample → rdata[0]).
  - GAP (GAP_CYCLES cycles): SS_n=1, MOSI=0; on entry pulse done (and rd_valid and update rdata if cmd=11); then → IDLE.
- Bit counter of 4 bits; saturates/resets per state, never wraps within a state.
- Reset: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rdata=0x00, state IDLE. Reset mid-frame aborts immediately: SS_n high on the next cycle, no done, rdata unchanged from its reset value.
- MISO is ignored outside RECV.
- Simultaneous start and done in the same cycle: start is ignored (busy still high in GAP).

## Timing
- SS_n, MOSI, busy, done, rd_valid, rdata all registered outputs.
- start accepted at edge E0 → SS_n low during T0 (from E0 to E12 for writes, E0 to E21 for cmd=11).
- Write/read-address frame: SS_n low 12 cycles; done asserts in the first GAP cycle (T12).
- Read-data frame: SS_n low 21 cycles; done, rd_valid and new rdata valid in T21.
- Back-to-back: next start accepted no earlier than GAP_CYCLES cycles after SS_n rises.
- Throughput: one MOSI bit per clk; no clock enable.

## Structure
- Shared package spi_pkg: cmd encodings (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11), state enumeration, FRAME_BITS=10, RD_BITS=8. Same package is referenced by the slave.
- One natural sub-module: spi_shift_reg (parallel-load 10-bit TX shifter plus 8-bit RX LSB-first capture register with shift enables); FSM and counter live in spi_master_ctrl.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → SS_n=1, MOSI=0, busy=0, rdata=0x00, done=0.
- Write address cmd=00, wdata=0xA5 → SS_n low 12 cycles; MOSI T1..T11 = 0,0,0,1,0,1,0,0,1,0,1; done at T12; rd_valid=0.
- Read data cmd=11 with MISO model driving 0x3C LSB first in T13..T20 → MOSI T1..T11 = 1,1,1,0×8; rdata=0x3C with rd_valid=done=1 in T21.
- start pulsed during SHIFT and during GAP → ignored; no second frame, SS_n stays high ≥GAP_CYCLES before next accepted start.
- rst_n low at T6 of a read-data frame → SS_n=1 next cycle, no done/rd_valid, rdata=0x00; subsequent cmd=01 wdata=0xFF frame completes normally.
- Back-to-back: cmd=10 wdata=0x12 then cmd=11 issued at first legal cycle → gap exactly GAP_CYCLES, both frames bit-exact, against the slave+RAM end-to-end returning previously written data.
